// File: rtl/sm_rotate_pkg.sv
// Shared constants and helpers for the pipelined barrel rotator.
// Optional feature macro: BARREL_ROTATOR_DIR_SEL_EN (per-word rotate direction).
package sm_rotate_pkg;

   // Default word width of the rotator.
   localparam int DATA_WIDTH_DEF = 32;

   // Number of shift-amount bits, which is also the number of pipeline stages.
   function automatic int shift_width_of(input int data_width);
      return $clog2(data_width);
   endfunction

   // Fixed rotate amount of stage k: the first stage handles the largest power of two.
   function automatic int stage_amount(input int shift_width, input int stage);
      return 1 << (shift_width - 1 - stage);
   endfunction

   // Rotate direction carried alongside each word when direction select is built in.
   typedef enum logic {
      DIR_RIGHT = 1'b0,
      DIR_LEFT  = 1'b1
   } rot_dir_e;

endpackage

// File: rtl/barrel_rotator_stage.sv
// One pipeline stage of the barrel rotator: a conditional fixed-amount rotate
// followed by the stage register (word, shift bits, valid) and its handshake.
// Optional feature macro: BARREL_ROTATOR_DIR_SEL_EN adds a carried direction bit.
module barrel_rotator_stage
   import sm_rotate_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int SHIFT_WIDTH = shift_width_of(DATA_WIDTH_DEF),
   parameter int STAGE       = 0
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic                   flush_in,
   input  logic                   i_valid,
   input  logic [DATA_WIDTH-1:0]  i_data,
   input  logic [SHIFT_WIDTH-1:0] i_shift,
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   input  logic                   i_dir,
`endif
   input  logic                   i_next_adv,
   output logic                   o_adv,
   output logic                   o_valid,
   output logic [DATA_WIDTH-1:0]  o_data,
   output logic [SHIFT_WIDTH-1:0] o_shift
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   ,
   output logic                   o_dir
`endif
);

   // Rotate amount of this stage and the shift bit that enables it.
   localparam int AMT = stage_amount(SHIFT_WIDTH, STAGE);
   localparam int BIT = SHIFT_WIDTH - 1 - STAGE;

   logic                   r_valid;
   logic [DATA_WIDTH-1:0]  r_data;
   logic [SHIFT_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0]  w_rotr;
   logic [DATA_WIDTH-1:0]  w_stage_data;
   logic                   w_adv;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   logic                   r_dir;
   logic [DATA_WIDTH-1:0]  w_rotl;
`endif

   // Fixed-amount rotations; AMT is always below DATA_WIDTH so both shifts are in range.
   assign w_rotr = (i_data >> AMT) | (i_data << (DATA_WIDTH - AMT));
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   assign w_rotl = (i_data << AMT) | (i_data >> (DATA_WIDTH - AMT));
`endif

   // Pick the rotated or pass-through word for this stage.
   always_comb begin
      w_stage_data = i_data;
      if (i_shift[BIT]) begin
`ifdef BARREL_ROTATOR_DIR_SEL_EN
         w_stage_data = (rot_dir_e'(i_dir) == DIR_LEFT) ? w_rotl : w_rotr;
`else
         w_stage_data = w_rotr;
`endif
      end
   end

   // A stage may take a new word when it is empty or its current word moves on.
   assign w_adv = !r_valid || i_next_adv;

   // Stage register: flush wins over loading, payload only loads for valid words.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_shift <= '0;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
         r_dir   <= 1'b0;
`endif
      end else begin
         if (flush_in) begin
            r_valid <= 1'b0;
         end else if (w_adv) begin
            r_valid <= i_valid;
         end
         if (w_adv && i_valid && !flush_in) begin
            r_data  <= w_stage_data;
            r_shift <= i_shift;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
            r_dir   <= i_dir;
`endif
         end
      end
   end

   assign o_adv   = w_adv;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_shift = r_shift;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   assign o_dir   = r_dir;
`endif

endmodule

// File: rtl/barrel_rotator_right_pipe.sv
// Pipelined right barrel rotator: SHIFT_WIDTH stages, each applying one
// power-of-two rotate, with valid/ready backpressure and synchronous flush.
// Optional feature macro: BARREL_ROTATOR_DIR_SEL_EN adds dir_in (0=right, 1=left).
module barrel_rotator_right_pipe
   import sm_rotate_pkg::*;
#(
   parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
   localparam int SHIFT_WIDTH = shift_width_of(DATA_WIDTH)
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic                   flush_in,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic [SHIFT_WIDTH-1:0] shift_number_in,
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   input  logic                   dir_in,
`endif
   input  logic                   valid_in,
   output logic                   ready_out,
   output logic [DATA_WIDTH-1:0]  data_after_shift_out,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic                   busy_out
);

   // Index 0 is the block input, index k+1 is the register of stage k.
   logic                   w_valid [0:SHIFT_WIDTH];
   logic [DATA_WIDTH-1:0]  w_data  [0:SHIFT_WIDTH];
   logic [SHIFT_WIDTH-1:0] w_shift [0:SHIFT_WIDTH];
   // w_adv[k] is stage k's advance; the entry past the last stage is the downstream ready.
   logic                   w_adv   [0:SHIFT_WIDTH];
   logic [SHIFT_WIDTH-1:0] w_stage_valid;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   logic                   w_dir   [0:SHIFT_WIDTH];

   assign w_dir[0] = dir_in;
`endif

   assign w_valid[0]           = valid_in;
   assign w_data[0]            = data_in;
   assign w_shift[0]           = shift_number_in;
   assign w_adv[SHIFT_WIDTH]   = ready_in;

   genvar gi;
   generate
      for (gi = 0; gi < SHIFT_WIDTH; gi = gi + 1) begin : g_stage
         barrel_rotator_stage #(
            .DATA_WIDTH  (DATA_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH),
            .STAGE       (gi)
         ) u_stage (
            .clk_in     (clk_in),
            .reset_in   (reset_in),
            .flush_in   (flush_in),
            .i_valid    (w_valid[gi]),
            .i_data     (w_data[gi]),
            .i_shift    (w_shift[gi]),
`ifdef BARREL_ROTATOR_DIR_SEL_EN
            .i_dir      (w_dir[gi]),
`endif
            .i_next_adv (w_adv[gi+1]),
            .o_adv      (w_adv[gi]),
            .o_valid    (w_valid[gi+1]),
            .o_data     (w_data[gi+1]),
            .o_shift    (w_shift[gi+1])
`ifdef BARREL_ROTATOR_DIR_SEL_EN
            ,
            .o_dir      (w_dir[gi+1])
`endif
         );

         assign w_stage_valid[gi] = w_valid[gi+1];
      end
   endgenerate

   // Input is accepted whenever the first stage can advance.
   assign ready_out            = w_adv[0];
   assign valid_out            = w_valid[SHIFT_WIDTH];
   assign data_after_shift_out = w_data[SHIFT_WIDTH];
   assign busy_out             = |w_stage_valid;

endmodule

// File: tb/tb_barrel_rotator_right_pipe.sv
// Self-checking bench for barrel_rotator_right_pipe (default build, right rotate).
module tb_barrel_rotator_right_pipe;

   localparam int W  = 32;
   localparam int SW = 5;

   logic          clk_in = 1'b0;
   logic          reset_in;
   logic          flush_in;
   logic [W-1:0]  data_in;
   logic [SW-1:0] shift_number_in;
   logic          valid_in;
   logic          ready_out;
   logic [W-1:0]  data_after_shift_out;
   logic          valid_out;
   logic          ready_in;
   logic          busy_out;
`ifdef BARREL_ROTATOR_DIR_SEL_EN
   logic          dir_in = 1'b0;
`endif

   barrel_rotator_right_pipe #(.DATA_WIDTH(W)) dut (
      .clk_in               (clk_in),
      .reset_in             (reset_in),
      .flush_in             (flush_in),
      .data_in              (data_in),
      .shift_number_in      (shift_number_in),
`ifdef BARREL_ROTATOR_DIR_SEL_EN
      .dir_in               (dir_in),
`endif
      .valid_in             (valid_in),
      .ready_out            (ready_out),
      .data_after_shift_out (data_after_shift_out),
      .valid_out            (valid_out),
      .ready_in             (ready_in),
      .busy_out             (busy_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] data;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   rand_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference rotations written bit by bit from the definition.
   function automatic logic [W-1:0] rotr_model(input logic [W-1:0] x, input int n);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = x[(i + n) % W];
      return r;
   endfunction

   function automatic logic [W-1:0] rotl_model(input logic [W-1:0] x, input int n);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[(i + n) % W] = x[i];
      return r;
   endfunction

   // Present one word and wait for it to be accepted; returns #1 after the accepting edge.
   task automatic send(input logic [W-1:0] x, input int n, input logic [W-1:0] expv, input bit lat);
      exp_t e;
      data_in         = x;
      shift_number_in = n[SW-1:0];
      valid_in        = 1'b1;
      for (int t = 0; t < 500; t++) begin
         @(negedge clk_in);
         if (ready_out && !flush_in) begin
            e.data = expv;
            e.acc  = cyc;
            e.lat  = lat;
            exp_q.push_back(e);
            @(posedge clk_in);
            #1;
            $display("send x=0x%08h n=%0d exp=0x%08h", x, n, expv);
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got ready_out=0 for 500 cycles, expected acceptance");
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk_in);
      check("drain_empty", exp_q.size(), 0);
      @(posedge clk_in);
      #1;
   endtask

   task automatic count_idle_outputs(input string name, input int cycles);
      int seen = 0;
      for (int t = 0; t < cycles; t++) begin
         @(negedge clk_in);
         if (valid_out) seen++;
      end
      check(name, seen, 0);
   endtask

   // Monitor: pops the scoreboard on every transfer and checks hold-during-stall.
   initial begin : monitor
      exp_t         e;
      bit           prev_stall = 1'b0;
      logic [W-1:0] prev_data  = '0;
      forever begin
         @(negedge clk_in);
         if (reset_in) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_valid", valid_out, 1);
               check("hold_data", data_after_shift_out, prev_data);
            end
            if (valid_out && ready_in) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: got 0x%08h, expected no output", data_after_shift_out);
               end else begin
                  e = exp_q.pop_front();
                  check("data", data_after_shift_out, e.data);
                  if (e.lat) check("latency", cyc - e.acc, SW);
                  $display("recv 0x%08h exp=0x%08h", data_after_shift_out, e.data);
               end
            end
            prev_stall = valid_out && !ready_in && !flush_in;
            prev_data  = data_after_shift_out;
         end
      end
   end

   initial begin : stimulus
      logic [W-1:0] x;
      int           n;
      reset_in        = 1'b1;
      flush_in        = 1'b0;
      valid_in        = 1'b0;
      ready_in        = 1'b1;
      data_in         = '0;
      shift_number_in = '0;
      rand_done       = 1'b0;

      repeat (3) @(posedge clk_in);
      #1;
      check("reset_valid_out", valid_out, 0);
      check("reset_data_out", data_after_shift_out, 0);
      check("reset_busy_out", busy_out, 0);
      reset_in = 1'b0;
      @(posedge clk_in);
      #1;
      check("ready_after_reset", ready_out, 1);

      // Single word with latency check.
      send(32'h1234_5678, 4, 32'h8123_4567, 1'b1);
      valid_in = 1'b0;
      drain();

      // Directed corner values, back to back.
      send(32'h8000_0001, 1, 32'hC000_0000, 1'b1);
      send(32'h1234_5678, 16, 32'h5678_1234, 1'b1);
      send(32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b1);
      valid_in = 1'b0;
      drain();

      // Eight back-to-back words with a three-cycle downstream stall.
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               x = $urandom;
               n = $urandom_range(0, W - 1);
               send(x, n, rotr_model(x, n), 1'b0);
            end
            valid_in = 1'b0;
         end
         begin
            repeat (6) @(posedge clk_in);
            #1;
            ready_in = 1'b0;
            @(negedge clk_in);
            check("ready_out_low_full", ready_out, 0);
            check("busy_while_full", busy_out, 1);
            repeat (3) @(posedge clk_in);
            #1;
            ready_in = 1'b1;
         end
      join
      drain();

      // Reset with three words in flight.
      for (int i = 0; i < 3; i++) begin
         x = $urandom;
         send(x, i + 3, rotr_model(x, i + 3), 1'b0);
      end
      valid_in = 1'b0;
      reset_in = 1'b1;
      #1;
      check("midreset_valid_out", valid_out, 0);
      check("midreset_data_out", data_after_shift_out, 0);
      check("midreset_busy_out", busy_out, 0);
      exp_q.delete();
      repeat (2) @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      count_idle_outputs("stale_after_reset", 10);
      @(posedge clk_in);
      #1;
      send(32'hA5A5_0F0F, 8, rotr_model(32'hA5A5_0F0F, 8), 1'b1);
      valid_in = 1'b0;
      drain();

      // Flush with a word presented in the same cycle.
      send(32'h1111_2222, 3, rotr_model(32'h1111_2222, 3), 1'b0);
      send(32'h3333_4444, 5, rotr_model(32'h3333_4444, 5), 1'b0);
      data_in         = 32'hCAFE_F00D;
      shift_number_in = 5'd7;
      valid_in        = 1'b1;
      flush_in        = 1'b1;
      @(posedge clk_in);
      #1;
      flush_in = 1'b0;
      valid_in = 1'b0;
      exp_q.delete();
      check("flush_busy_out", busy_out, 0);
      check("flush_valid_out", valid_out, 0);
      count_idle_outputs("output_after_flush", 12);
      @(posedge clk_in);
      #1;

      // Round trip through the left rotate model for every amount.
      for (int k = 0; k < W; k++) begin
         x = $urandom;
         send(rotl_model(x, k), k, x, 1'b1);
      end
      valid_in = 1'b0;
      drain();

      // Random traffic with random downstream backpressure.
      fork
         begin
            for (int t = 0; t < 3000 && !rand_done; t++) begin
               @(posedge clk_in);
               #1;
               ready_in = ($urandom_range(0, 3) != 0);
            end
            ready_in = 1'b1;
         end
         begin
            for (int i = 0; i < 60; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  valid_in = 1'b0;
                  @(posedge clk_in);
                  #1;
               end
               x = $urandom;
               n = $urandom_range(0, W - 1);
               send(x, n, rotr_model(x, n), 1'b0);
            end
            valid_in = 1'b0;
            rand_done = 1'b1;
         end
      join
      ready_in = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/barrel_rotator_right_pipe.md
BARREL_ROTATOR_RIGHT_PIPE -- requirements
Module: barrel_rotator_right_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width; it is a power of two, 8..64.
REQ-002 SHALL derive localparam SHIFT_WIDTH = clog2(DATA_WIDTH), which is also the stage count (5 at default).
REQ-003 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port flush_in, input, 1, synchronous pipeline clear.
REQ-006 SHALL have port data_in, input, DATA_WIDTH, the word to rotate.
REQ-007 SHALL have port shift_number_in, input, SHIFT_WIDTH, the right-rotate amount.
REQ-008 SHALL have port valid_in, input, 1, input word valid.
REQ-009 SHALL have port ready_out, output, 1, block accepts input this cycle.
REQ-010 SHALL have port data_after_shift_out, output, DATA_WIDTH, the rotated result.
REQ-011 SHALL have port valid_out, output, 1, result valid.
REQ-012 SHALL have port ready_in, input, 1, downstream accepts the result.
REQ-013 SHALL have port busy_out, output, 1, asserted when any stage holds a valid word.

Function
REQ-014 SHALL compute data_after_shift_out = data_in rotated right by shift_number_in; this is the inverse of the team's left barrel rotate, so rotr(rotl(x,n),n) = x.
REQ-015 SHALL be a SHIFT_WIDTH-stage pipeline; stage k (k=0..SHIFT_WIDTH-1) rotates right by 2^(SHIFT_WIDTH-1-k) when the matching shift bit is 1, else passes the word unchanged.
REQ-016 SHALL register, per stage, the partial word, the remaining shift bits, and a valid flag.
REQ-017 SHALL accept an input when valid_in && ready_out; latency is exactly SHIFT_WIDTH cycles from acceptance to valid_out with no stall.
REQ-018 SHALL advance stage k when it is empty or stage k+1 advances; the last stage advances when valid_out==0 or ready_in==1.
REQ-019 SHALL drive ready_out = stage-0 can advance, giving throughput of one word per cycle under ready_in==1.
REQ-020 SHALL hold data_after_shift_out and valid_out stable while valid_out==1 and ready_in==0; no word is lost or duplicated.
REQ-021 SHALL handle shift_number_in==0 by outputting data_in unchanged after full latency.
REQ-022 SHALL, when flush_in==1, clear every stage valid at the next edge; an input presented in the same cycle is dropped, and flush has priority over acceptance.
REQ-023 SHALL compute busy_out as the OR of all stage valid flags, combinationally.

Reset
REQ-024 SHALL, on reset_in assertion, immediately clear all valid flags and data/shift registers to 0, giving valid_out=0, data_after_shift_out=0 and busy_out=0.
REQ-025 SHALL discard in-flight words on reset mid-operation; the first accepted word after reset deassertion appears after exactly SHIFT_WIDTH cycles.

Configuration
REQ-026 SHALL support macro BARREL_ROTATOR_DIR_SEL_EN; when defined, it adds input dir_in (1 bit, 0=right, 1=left), carried per stage, with left rotation by the same amounts.
REQ-027 SHALL, without BARREL_ROTATOR_DIR_SEL_EN, have no dir_in port and rotate right only, with identical latency either way.

Structure
REQ-028 SHALL place DATA_WIDTH default, SHIFT_WIDTH derivation and stage-amount constants in shared package sm_rotate_pkg.
REQ-029 SHALL instantiate one sub-module per stage, barrel_rotator_stage, which holds one conditional fixed-amount rotate plus its pipeline register and handshake.

Verification
REQ-030 SHALL test: 0x12345678, shift 4, ready_in=1 -> 0x81234567 with valid_out 5 cycles after accept.
REQ-031 SHALL test: 0x80000001 shift 1 -> 0xC0000000; 0x12345678 shift 16 -> 0x56781234; shift 0 -> unchanged.
REQ-032 SHALL test: 8 back-to-back words, ready_in low 3 cycles mid-stream -> all 8 results in order, none lost or duplicated, and ready_out low while full.
REQ-033 SHALL test: reset_in pulsed with 3 words in flight -> outputs 0 immediately, no stale valid_out afterwards.
REQ-034 SHALL test: flush_in with valid_in both high -> busy_out 0 next cycle and that word is never output.
REQ-035 SHALL test: random x and n fed through the team left rotator then this block (right mode) -> output equals x for all 32 amounts.
